// File: rtl/fft8_pkg.sv
// Shared types and address arithmetic for the 8-point radix-2 DIT FFT sequencer.
// Contents: transform size constants, FSM state enum, 3-bit address/twiddle
// types, 2-bit stage type, the write-back bundle and butterfly address helpers.
package fft8_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = 3;
  localparam int unsigned NBF   = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  typedef logic [2:0] addr_t;
  typedef logic [2:0] tw_t;
  typedef logic [1:0] stage_t;
  typedef logic [1:0] bf_t;

  typedef struct packed {
    logic  v;
    addr_t a;
    addr_t b;
  } wb_t;

  function automatic addr_t bf_span(input stage_t s);
    return addr_t'(3'd1 << s);
  endfunction

  function automatic addr_t bf_pos(input stage_t s, input bf_t k);
    return {1'b0, k} & (bf_span(s) - 3'd1);
  endfunction

  // Butterfly k of stage s: group base plus position inside the group.
  function automatic addr_t bf_addr_a(input stage_t s, input bf_t k);
    return addr_t'((({1'b0, k} >> s) << (s + 2'd1)) + bf_pos(s, k));
  endfunction

  function automatic addr_t bf_addr_b(input stage_t s, input bf_t k);
    return bf_addr_a(s, k) + bf_span(s);
  endfunction

  function automatic tw_t bf_tw(input stage_t s, input bf_t k);
    return tw_t'(bf_pos(s, k) << (2'd2 - s));
  endfunction

endpackage

// File: rtl/fft8_addr_dly.sv
// D-deep delay line for the write-back bundle {valid, addr_a, addr_b}.
// Ports: clk, rst_n (async active-low clear), in_wb (read-side bundle),
// out_wb (bundle delayed by D cycles). D=0 is a combinational pass-through.
module fft8_addr_dly
  import fft8_pkg::*;
#(
  parameter int unsigned D = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  wb_t  in_wb,
  output wb_t  out_wb
);

  generate
    if (D == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_wb         = in_wb;
    end else begin : g_sr
      wb_t sr_q [D];
      wb_t sr_d [D];

      always_comb begin
        sr_d[0] = in_wb;
        for (int unsigned i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < D; i++) sr_q[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < D; i++) sr_q[i] <= sr_d[i];
        end
      end

      assign out_wb = sr_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/fft8_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT 8-point FFT (3 stages x 4 butterflies).
// Issues operand read addresses and twiddle index each ISSUE cycle, delays them
// by D = TW_LAT + BF_LAT to form write-back strobes, drains between stages so the
// next stage's first read follows the previous stage's last write by one cycle.
// Ports: clk, rst_n (async active-low), start, inv (only with FFT8_IFFT_EN:
// conjugate twiddles), busy, rd_en, rd_addr_a/b, tw_addr, wr_en, wr_addr_a/b,
// stage, done (one-cycle pulse).
// Optional macro: FFT8_IFFT_EN adds the inv port and conjugate twiddle mapping.
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int unsigned TW_LAT = 1,
  parameter int unsigned BF_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FFT8_IFFT_EN
  input  logic       inv,
`endif
  output logic       busy,
  output logic       rd_en,
  output logic [2:0] rd_addr_a,
  output logic [2:0] rd_addr_b,
  output logic [2:0] tw_addr,
  output logic       wr_en,
  output logic [2:0] wr_addr_a,
  output logic [2:0] wr_addr_b,
  output logic [1:0] stage,
  output logic       done
);

  localparam int unsigned D          = TW_LAT + BF_LAT;
  localparam logic [3:0]  D_CNT      = 4'(D);
  localparam bf_t         LAST_BF    = bf_t'(NBF - 1);
  localparam stage_t      LAST_STAGE = stage_t'(LOG2N - 1);

  state_e     state_q, state_d;
  stage_t     stage_q, stage_d;
  bf_t        k_q, k_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stage_end;
  wb_t        rd_bus, wr_bus;
  tw_t        tw_raw;
`ifdef FFT8_IFFT_EN
  logic       inv_q, inv_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
`ifdef FFT8_IFFT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
`ifdef FFT8_IFFT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    stage_end = 1'b0;
`ifdef FFT8_IFFT_EN
    inv_d     = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
`ifdef FFT8_IFFT_EN
          inv_d   = inv;
`endif
        end
      end
      ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == LAST_BF) begin
          // With no pipeline delay there is nothing to drain.
          if (D == 0) begin
            stage_end = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = D_CNT;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) stage_end = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (stage_end) begin
      if (stage_q == LAST_STAGE) begin
        state_d = DONE;
      end else begin
        state_d = ISSUE;
        stage_d = stage_q + 2'd1;
        k_d     = '0;
      end
    end
  end

  always_comb begin
    rd_bus  = '0;
    tw_raw  = '0;
    tw_addr = '0;
    busy    = (state_q == ISSUE) || (state_q == DRAIN);
    done    = (state_q == DONE);
    stage   = stage_q;
    if (state_q == ISSUE) begin
      rd_bus.v = 1'b1;
      rd_bus.a = bf_addr_a(stage_q, k_q);
      rd_bus.b = bf_addr_b(stage_q, k_q);
      tw_raw   = bf_tw(stage_q, k_q);
      tw_addr  = tw_raw;
`ifdef FFT8_IFFT_EN
      // W8^-n is entry (8-n) mod 8 of the same table.
      if (inv_q) tw_addr = 3'd0 - tw_raw;
`endif
    end
  end

  assign rd_en     = rd_bus.v;
  assign rd_addr_a = rd_bus.a;
  assign rd_addr_b = rd_bus.b;

  fft8_addr_dly #(.D(D)) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_wb  (rd_bus),
    .out_wb (wr_bus)
  );

  assign wr_en     = wr_bus.v;
  assign wr_addr_a = wr_bus.a;
  assign wr_addr_b = wr_bus.b;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Scoreboard bench for fft8_seq_ctrl: DUT0 uses default latencies (D=3),
// DUT1 uses TW_LAT=0, BF_LAT=1 (D=1). Stimulus pushes expected reads, writes,
// done pulses and level checks into queues; one monitor compares at negedge.
module tb_fft8_seq_ctrl;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  stg;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  t;
  } ev_t;

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    int unsigned kind;   // 0 busy, 1 done, 2 full output vector
    logic [20:0] exp;
  } lv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       start [2];
`ifdef FFT8_IFFT_EN
  logic       inv   [2];
`endif
  logic       busy  [2];
  logic       rd_en [2];
  logic [2:0] rd_a  [2];
  logic [2:0] rd_b  [2];
  logic [2:0] tw    [2];
  logic       wr_en [2];
  logic [2:0] wr_a  [2];
  logic [2:0] wr_b  [2];
  logic [1:0] stage [2];
  logic       done  [2];

  fft8_seq_ctrl #(.TW_LAT(1), .BF_LAT(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
`ifdef FFT8_IFFT_EN
    .inv(inv[0]),
`endif
    .busy(busy[0]), .rd_en(rd_en[0]), .rd_addr_a(rd_a[0]), .rd_addr_b(rd_b[0]),
    .tw_addr(tw[0]), .wr_en(wr_en[0]), .wr_addr_a(wr_a[0]), .wr_addr_b(wr_b[0]),
    .stage(stage[0]), .done(done[0])
  );

  fft8_seq_ctrl #(.TW_LAT(0), .BF_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
`ifdef FFT8_IFFT_EN
    .inv(inv[1]),
`endif
    .busy(busy[1]), .rd_en(rd_en[1]), .rd_addr_a(rd_a[1]), .rd_addr_b(rd_b[1]),
    .tw_addr(tw[1]), .wr_en(wr_en[1]), .wr_addr_a(wr_a[1]), .wr_addr_b(wr_b[1]),
    .stage(stage[1]), .done(done[1])
  );

  // Hand-computed butterfly order: stage 0, stage 1, stage 2.
  logic [2:0] ea  [12] = '{3'd0,3'd2,3'd4,3'd6, 3'd0,3'd1,3'd4,3'd5, 3'd0,3'd1,3'd2,3'd3};
  logic [2:0] eb  [12] = '{3'd1,3'd3,3'd5,3'd7, 3'd2,3'd3,3'd6,3'd7, 3'd4,3'd5,3'd6,3'd7};
  logic [2:0] etf [12] = '{3'd0,3'd0,3'd0,3'd0, 3'd0,3'd2,3'd0,3'd2, 3'd0,3'd1,3'd2,3'd3};
  logic [2:0] eti [12] = '{3'd0,3'd0,3'd0,3'd0, 3'd0,3'd6,3'd0,3'd6, 3'd0,3'd7,3'd6,3'd5};

  ev_t         rdq [2][$];
  ev_t         wrq [2][$];
  int unsigned dq  [2][$];
  lv_t         lvq [$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  bit  fin    = 1'b0;

  function automatic logic [20:0] outs(input int unsigned i);
    return {busy[i], rd_en[i], rd_a[i], rd_b[i], tw[i], wr_en[i], wr_a[i], wr_b[i],
            stage[i], done[i]};
  endfunction

  task automatic push_run(input int unsigned i, input int unsigned d,
                          input int unsigned base, input bit iv);
    for (int unsigned n = 0; n < 12; n++) begin
      ev_t e;
      e.cyc = base + 1 + (n / 4) * (4 + d) + (n % 4);
      e.stg = 2'(n / 4);
      e.a   = ea[n];
      e.b   = eb[n];
      e.t   = iv ? eti[n] : etf[n];
      rdq[i].push_back(e);
      e.cyc = e.cyc + d;
      wrq[i].push_back(e);
    end
    dq[i].push_back(base + 1 + 3 * (4 + d));
  endtask

  task automatic push_lv(input int unsigned i, input int unsigned kind, input logic [20:0] exp);
    lv_t l;
    l.cyc  = cyc;
    l.dut  = i;
    l.kind = kind;
    l.exp  = exp;
    lvq.push_back(l);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  ev_t         me;
  lv_t         ml;
  int unsigned md;
  logic [20:0] got;

  always @(negedge clk) begin
    while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
      ml = lvq.pop_front();
      got = (ml.kind == 0) ? 21'(busy[ml.dut]) :
            (ml.kind == 1) ? 21'(done[ml.dut]) : outs(ml.dut);
      checks++;
      if (ml.cyc != cyc || got !== ml.exp) begin
        errors++;
        $display("FAIL level%0d dut%0d cyc %0d: got %0h expected %0h at cyc %0d",
                 ml.kind, ml.dut, cyc, got, ml.exp, ml.cyc);
      end
    end
    for (int unsigned i = 0; i < 2; i++) begin
      while (rdq[i].size() > 0 && rdq[i][0].cyc < cyc) begin
        me = rdq[i].pop_front();
        checks++; errors++;
        $display("FAIL rd_missing dut%0d: no read at cyc %0d, expected a=%0d b=%0d", i, me.cyc, me.a, me.b);
      end
      while (wrq[i].size() > 0 && wrq[i][0].cyc < cyc) begin
        me = wrq[i].pop_front();
        checks++; errors++;
        $display("FAIL wr_missing dut%0d: no write at cyc %0d, expected a=%0d b=%0d", i, me.cyc, me.a, me.b);
      end
      while (dq[i].size() > 0 && dq[i][0] < cyc) begin
        md = dq[i].pop_front();
        checks++; errors++;
        $display("FAIL done_missing dut%0d: no done, expected at cyc %0d", i, md);
      end
      if (rd_en[i]) begin
        checks++;
        if (rdq[i].size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected dut%0d cyc %0d: got a=%0d b=%0d, expected no read", i, cyc, rd_a[i], rd_b[i]);
        end else begin
          me = rdq[i].pop_front();
          if (me.cyc != cyc || me.a !== rd_a[i] || me.b !== rd_b[i] || me.t !== tw[i] || me.stg !== stage[i]) begin
            errors++;
            $display("FAIL rd dut%0d: got cyc %0d s=%0d a=%0d b=%0d tw=%0d expected cyc %0d s=%0d a=%0d b=%0d tw=%0d",
                     i, cyc, stage[i], rd_a[i], rd_b[i], tw[i], me.cyc, me.stg, me.a, me.b, me.t);
          end
        end
      end
      if (wr_en[i]) begin
        checks++;
        if (wrq[i].size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected dut%0d cyc %0d: got a=%0d b=%0d, expected no write", i, cyc, wr_a[i], wr_b[i]);
        end else begin
          me = wrq[i].pop_front();
          if (me.cyc != cyc || me.a !== wr_a[i] || me.b !== wr_b[i]) begin
            errors++;
            $display("FAIL wr dut%0d: got cyc %0d a=%0d b=%0d expected cyc %0d a=%0d b=%0d",
                     i, cyc, wr_a[i], wr_b[i], me.cyc, me.a, me.b);
          end
        end
      end
      if (done[i]) begin
        checks++;
        if (dq[i].size() == 0) begin
          errors++;
          $display("FAIL done_unexpected dut%0d: got done at cyc %0d, expected none", i, cyc);
        end else begin
          md = dq[i].pop_front();
          if (md != cyc) begin
            errors++;
            $display("FAIL done dut%0d: got cyc %0d expected cyc %0d", i, cyc, md);
          end
        end
      end
    end
    if (fin) begin
      for (int unsigned i = 0; i < 2; i++) begin
        checks++;
        if (rdq[i].size() != 0 || wrq[i].size() != 0 || dq[i].size() != 0) begin
          errors++;
          $display("FAIL leftover dut%0d: got %0d/%0d/%0d pending rd/wr/done, expected 0/0/0",
                   i, rdq[i].size(), wrq[i].size(), dq[i].size());
        end
      end
      checks++;
      if (lvq.size() != 0) begin
        errors++;
        $display("FAIL leftover_level: got %0d pending, expected 0", lvq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  int unsigned base;

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
`ifdef FFT8_IFFT_EN
    inv[0] = 1'b0; inv[1] = 1'b0;
`endif
    step(1);
    push_lv(0, 2, '0);
    push_lv(1, 2, '0);
    step(2);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    step(1);

    // Both DUTs start together; cycle 0 is the cycle start is held high.
    base = cyc;
    start[0] = 1'b1; start[1] = 1'b1;
    push_run(0, 3, base, 1'b0);
    push_run(1, 1, base, 1'b0);
    step(1);
    start[0] = 1'b0; start[1] = 1'b0;
    step(4);
    push_lv(0, 0, 21'd1);          // busy mid-run; start here is ignored
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    step(16);
    push_lv(0, 0, 21'd0);          // cycle 22: busy low, done high, start ignored
    push_lv(0, 1, 21'd1);
    start[0] = 1'b1;
    step(1);

    // Cycle 23: start held, accepted -> first read at 24.
    base = cyc;
    push_run(0, 3, base, 1'b0);
    step(1);
    start[0] = 1'b0;
    step(9);

    // Asynchronous reset mid-run: everything pending is discarded.
    rst_n[0] = 1'b0;
    rdq[0].delete();
    wrq[0].delete();
    dq[0].delete();
    push_lv(0, 2, '0);
    step(1);
    push_lv(0, 2, '0);
    step(1);
    rst_n[0] = 1'b1;
    step(3);

    base = cyc;
    start[0] = 1'b1;
    push_run(0, 3, base, 1'b0);
`ifdef FFT8_IFFT_EN
    start[1] = 1'b1;
    inv[1]   = 1'b1;
    push_run(1, 1, base, 1'b1);
`endif
    step(1);
    start[0] = 1'b0; start[1] = 1'b0;
`ifdef FFT8_IFFT_EN
    inv[1] = 1'b0;
`endif
    step(30);
    fin = 1'b1;
  end

endmodule
